fetch_pc_ctrl: RTL and testbench

Program-counter owner and instruction-fetch sequencer for the multi-cycle miniLA core. Holds the architectural PC and presents it to the next-PC unit. Accepts resolved redirects (taken branch, jump) from the next-PC unit and runs a request/acknowledge handshake to instruction memory. Delivers one instruction at a time to decode over a valid/ready handshake.

---
 rtl/fetch_pc_ctrl_pkg.sv | 26 ++
 rtl/fetch_pc_ctrl_if.sv | 34 +++
 rtl/fetch_pc_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared core definitions: fetch FSM states, reset PC, instruction size
// and the next-PC operation encodings used by both control and fetch.
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'h1C00_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    NPC_PC4,
    NPC_BRC,
    NPC_JMP,
    NPC_PC4_ADD
  } npc_op_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch bus: instruction-memory request/ack plus decode valid/ready.
// master = fetch_pc_ctrl side, slave = memory/decode side.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output if_req,
    output if_addr,
    output inst,
    output inst_valid,
    input  if_ack,
    input  if_rdata,
    input  inst_ready
  );

  modport slave (
    input  if_req,
    input  if_addr,
    input  inst,
    input  inst_valid,
    output if_ack,
    output if_rdata,
    output inst_ready
  );

endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC owner and fetch sequencer: holds pc, fetches via req/ack, hands one
// instruction at a time to decode; ports: clk, rst, pc, redirect, stall, bus, fault, fetch_cnt.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            pc,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  fetch_pc_ctrl_if.master        bus,
  output logic                   fault,
  output logic [31:0]            fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic         iv_q;
  logic [31:0]  cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         rv_bad;

  assign rv_bad = redirect_valid && misaligned(redirect_pc);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (rv_bad) begin
          state_d = FAULT;
          pend_d  = 1'b0;
        end else if (bus.if_ack) begin
          // Data returned for a stale pc is dropped; the live
          // redirect wins over the one stored earlier.
          pend_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (pend_q) begin
            pc_d = pend_pc_q;
          end else begin
            inst_d  = bus.if_rdata;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn: remember the target.
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          if (rv_bad) begin
            state_d = FAULT;
          end else begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end
        end else if (bus.inst_ready && !stall) begin
          pc_d    = pc_q + INST_BYTES;
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
        end
      end
      FAULT: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      iv_q      <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      iv_q      <= (state_d == HOLD);
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc             = pc_q;
  assign bus.if_addr    = pc_q;
  assign bus.if_req     = (state_q == REQ);
  assign bus.inst       = inst_q;
  assign bus.inst_valid = iv_q;
  assign fault          = (state_q == FAULT);
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios then random traffic,
// every cycle checked against a behavioural fetch model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        fault;
  logic [31:0] fetch_cnt;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .bus            (bus),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Model: the block is either booting, waiting on memory,
  // holding an instruction for decode, or dead after a bad redirect.
  logic [31:0] m_pc, m_inst, m_cnt, m_pend_pc;
  bit          m_boot, m_have, m_dead, m_pend;

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h1C00_0000; m_inst = '0; m_cnt = '0;
      m_boot = 1; m_have = 0; m_dead = 0; m_pend = 0;
    end else if (m_dead) begin
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_have) begin
      if (redirect_valid) begin
        m_have = 0;
        if (redirect_pc % 4 != 0) m_dead = 1;
        else m_pc = redirect_pc;
      end else if (bus.inst_ready && !stall) begin
        m_have = 0;
        m_pc = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (redirect_valid && redirect_pc % 4 != 0) begin
        m_dead = 1; m_pend = 0;
      end else if (bus.if_ack) begin
        if (redirect_valid) m_pc = redirect_pc;
        else if (m_pend) m_pc = m_pend_pc;
        else begin m_inst = bus.if_rdata; m_have = 1; end
        m_pend = 0;
      end else if (redirect_valid) begin
        m_pend = 1; m_pend_pc = redirect_pc;
      end
    end
  endtask

  task automatic compare();
    check("pc", pc, m_pc);
    check("if_addr", bus.if_addr, m_pc);
    check("if_req", {31'b0, bus.if_req},
          {31'b0, !m_boot && !m_have && !m_dead});
    check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_have});
    check("fault", {31'b0, fault}, {31'b0, m_dead});
    check("fetch_cnt", fetch_cnt, m_cnt);
    if (m_have) check("inst", bus.inst, m_inst);
    else if (m_boot) check("inst_rst", bus.inst, m_inst);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input bit r, input bit rv, input logic [31:0] rpc,
                       input bit st, input bit ack,
                       input logic [31:0] rd, input bit rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; stall = st;
    bus.if_ack = ack; bus.if_rdata = rd; bus.inst_ready = rdy;
  endtask

  logic [31:0] saved;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    check("rst_addr", bus.if_addr, 32'h1C00_0000);

    // zero-wait fetch
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    check("boot_req", {31'b0, bus.if_req}, 32'd1);
    check("boot_addr", bus.if_addr, 32'h1C00_0000);
    drive(0, 0, 0, 0, 1, 32'h0280_0400, 1); cycle();
    check("zw_inst", bus.inst, 32'h0280_0400);
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    check("seq_addr", bus.if_addr, 32'h1C00_0004);

    // redirect during a slow request
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 32'h1C00_0100, 0, 0, 0, 0); cycle();
    check("req_held", {31'b0, bus.if_req}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0); cycle();
    check("redir_addr", bus.if_addr, 32'h1C00_0100);
    check("redir_drop", {31'b0, bus.inst_valid}, 32'd0);

    // stall in HOLD
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 0); cycle();
    saved = fetch_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0, 1); cycle();
      check("stall_inst", bus.inst, 32'h1234_5678);
      check("stall_cnt", fetch_cnt, saved);
    end
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    check("unstall_cnt", fetch_cnt, saved + 1);
    check("unstall_pc", pc, 32'h1C00_0104);

    // redirect beats ready and stall
    drive(0, 0, 0, 0, 1, 32'h1111_2222, 0); cycle();
    saved = fetch_cnt;
    drive(0, 1, 32'h1C00_0040, 1, 0, 0, 1); cycle();
    check("prio_addr", bus.if_addr, 32'h1C00_0040);
    check("prio_cnt", fetch_cnt, saved);

    // misaligned redirect
    drive(0, 0, 0, 0, 1, 32'h3333_4444, 0); cycle();
    drive(0, 1, 32'h1C00_0042, 0, 0, 0, 1); cycle();
    check("fault_set", {31'b0, fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h1C00_0200, 0, 1, 0, 1); cycle();
      check("fault_noreq", {31'b0, bus.if_req}, 32'd0);
    end
    drive(1, 0, 0, 0, 0, 0, 0); cycle();
    check("fault_clr", {31'b0, fault}, 32'd0);
    check("fault_rstpc", pc, 32'h1C00_0000);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // pc wrap
    drive(0, 0, 0, 0, 1, 32'h5555_6666, 0); cycle();
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 32'h7777_8888, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    check("wrap_addr", bus.if_addr, 32'h0000_0000);
    drive(1, 0, 0, 0, 0, 0, 0); cycle();
    check("rst_midreq", {31'b0, bus.if_req}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      bit r;
      t = $urandom;
      if ($urandom_range(0, 19) != 0) t[1:0] = 2'b00;
      r = ($urandom_range(0, 299) == 0) ||
          (m_dead && $urandom_range(0, 9) == 0);
      drive(r, $urandom_range(0, 7) == 0, t,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
